// File: rtl/gain_scaler_mc.sv
// Multi-channel two-stage fractional gain: out = round(in * coef / 2^(COEF_W-1)),
// saturated to DATA_W, with per-channel coefficients and saturation telemetry.
module gain_scaler_mc #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2,
    parameter int COEF_RST = 32766
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CH_W-1:0]            in_ch,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic                       coef_wr,
    input  logic [CH_W-1:0]            coef_ch,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH_W-1:0]            out_ch,
    output logic signed [DATA_W-1:0]   out_data,
    output logic [CHANNELS-1:0]        sat_flag,
    input  logic                       sat_clr,
    output logic [15:0]                sat_count
);

    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [PW-1:0] HALF = {{(PW-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
    localparam logic signed [PW-1:0] MAXV = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Round half toward +inf, then drop the Q1.(COEF_W-1) fraction bits.
    function automatic logic signed [PW-1:0] round_p(input logic signed [PW-1:0] p);
        return (p + HALF) >>> (COEF_W - 1);
    endfunction

    function automatic logic is_sat(input logic signed [PW-1:0] r);
        return (r > MAXV) || (r < MINV);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_val(input logic signed [PW-1:0] r);
        if (r > MAXV) return MAXV[DATA_W-1:0];
        if (r < MINV) return MINV[DATA_W-1:0];
        return r[DATA_W-1:0];
    endfunction

    logic signed [COEF_W-1:0] coef [CHANNELS];
    logic                     adv;
    logic                     accept;
    logic                     ch_ok_in;
    logic                     ch_ok_wr;
    logic signed [PW-1:0]     din_x;
    logic signed [PW-1:0]     cf_x;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     prod_p1;
    logic signed [PW-1:0]     rnd;
    logic [CH_W-1:0]          ch_p1;
    logic                     ok_p1;
    logic                     vld_p1;
    logic                     sat_evt;
    logic [CHANNELS-1:0]      evt_vec;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;
    assign accept   = in_valid && in_ready;
    assign ch_ok_in = int'(in_ch) < CHANNELS;
    assign ch_ok_wr = int'(coef_ch) < CHANNELS;

    // Out-of-range channels multiply by zero so they can never saturate.
    always_comb begin
        din_x = in_data;
        cf_x  = '0;
        if (ch_ok_in) cf_x = coef[in_ch];
        prod  = din_x * cf_x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) coef[c] <= COEF_W'(COEF_RST);
        end else if (coef_wr && ch_ok_wr) begin
            coef[coef_ch] <= coef_data;
        end
    end

    // ---- stage 1: full-precision product ----
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else if (adv) vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            prod_p1 <= prod;
            ch_p1   <= in_ch;
            ok_p1   <= ch_ok_in;
        end
    end

    // ---- stage 2: round, saturate, output register ----
    assign rnd     = round_p(prod_p1);
    assign sat_evt = adv && vld_p1 && ok_p1 && is_sat(rnd);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (adv) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_ch   <= ch_p1;
                out_data <= ok_p1 ? sat_val(rnd) : '0;
            end
        end
    end

    always_comb begin
        evt_vec = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (sat_evt && int'(ch_p1) == c) evt_vec[c] = 1'b1;
    end

    // A clear coinciding with a new event leaves only that event recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag  <= '0;
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_flag  <= evt_vec;
            sat_count <= sat_evt ? 16'd1 : 16'd0;
        end else if (sat_evt) begin
            sat_flag <= sat_flag | evt_vec;
            if (sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
        end
    end

endmodule
